// File: rtl/pc_gen_pkg.sv
// Shared types for the program-counter generator: next-PC source selection.
package pc_gen_pkg;

  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_HOLD,
    SEL_RET,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_SEQ
  } pc_sel_e;

endpackage

// File: rtl/pc_gen_if.sv
// Control and status bundle between the fetch controller (master) and pc_gen (slave).
interface pc_gen_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             trap;
  logic [WIDTH-1:0] trap_vec;
  logic             branch;
  logic [WIDTH-1:0] immediate;
  logic             jump;
  logic [WIDTH-1:0] target;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc_out_reg;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_underflow;

  modport master (
    output stall, trap, trap_vec, branch, immediate, jump, target, call, ret,
    input  pc_out_reg, ras_empty, ras_full, ras_underflow
  );

  modport slave (
    input  stall, trap, trap_vec, branch, immediate, jump, target, call, ret,
    output pc_out_reg, ras_empty, ras_full, ras_underflow
  );
endinterface

// File: rtl/pc_gen_ras.sv
// Circular return-address stack; a push when full silently overwrites the oldest entry.
module pc_gen_ras #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full
);
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] stack_q [RAS_DEPTH];
  logic [PW-1:0]    sp_q, sp_d, top_idx, wr_idx;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign top_idx  = sp_q - PW'(1);
  assign top_data = stack_q[top_idx];
  assign pop_ok   = pop && !empty;

  // Simultaneous push+pop rewrites the top slot in place so the depth is unchanged.
  assign wr_idx = pop_ok ? top_idx : sp_q;

  always_comb begin
    sp_d    = sp_q;
    count_d = count_q;
    if (push && !pop_ok) begin
      sp_d    = sp_q + PW'(1);
      count_d = full ? count_q : count_q + CW'(1);
    end else if (pop_ok && !push) begin
      sp_d    = top_idx;
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
      if (push) begin
        stack_q[wr_idx] <= push_data;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: prioritised next-PC selection with a return-address stack.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] STEP         = WIDTH'(1),
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);
  pc_sel_e          sel;
  logic [WIDTH-1:0] pc_q, pc_d, seq_pc, ras_top;
  logic             ras_push, ras_pop, ras_empty, ras_full;
  logic             uf_q, uf_d;
  logic             active;

  // Trap and stall both freeze the stack; only an unfrozen cycle may push, pop or underflow.
  assign active   = !bus.trap && !bus.stall;
  assign seq_pc   = pc_q + STEP;
  assign ras_push = active && bus.call;
  assign ras_pop  = (sel == SEL_RET);
  assign uf_d     = active && bus.ret && ras_empty;

  always_comb begin
    sel = SEL_SEQ;
    if (bus.trap)                     sel = SEL_TRAP;
    else if (bus.stall)               sel = SEL_HOLD;
    else if (bus.ret && !ras_empty)   sel = SEL_RET;
    else if (bus.jump)                sel = SEL_JUMP;
    else if (bus.branch)              sel = SEL_BRANCH;
  end

  always_comb begin
    pc_d = seq_pc;
    case (sel)
      SEL_TRAP:   pc_d = bus.trap_vec;
      SEL_HOLD:   pc_d = pc_q;
      SEL_RET:    pc_d = ras_top;
      SEL_JUMP:   pc_d = bus.target;
      SEL_BRANCH: pc_d = pc_q + bus.immediate;
      default:    pc_d = seq_pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_VECTOR;
      uf_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      uf_q <= uf_d;
    end
  end

  pc_gen_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_pc),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign bus.pc_out_reg    = pc_q;
  assign bus.ras_empty     = ras_empty;
  assign bus.ras_full      = ras_full;
  assign bus.ras_underflow = uf_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table, randomized run against a queue-based model, async reset.
module tb_pc_gen;
  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic          stall, trap, branch, jump, call, ret;
    logic [W-1:0]  tv, imm, tgt;
  } in_t;

  typedef struct {
    in_t          in;
    logic [W-1:0] pc;
    logic         e, f, u;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: PC value and return addresses as a bounded queue (newest at back).
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stack[$];
  logic         m_uf;

  pc_gen_if #(.WIDTH(W)) bus ();

  pc_gen #(
    .WIDTH        (W),
    .STEP         (32'd1),
    .RESET_VECTOR (32'd0),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic in_t mk_in(logic st, logic tr, logic br, logic jp, logic ca, logic re,
                                logic [W-1:0] tv, logic [W-1:0] imm, logic [W-1:0] tgt);
    in_t i;
    i.stall = st; i.trap = tr; i.branch = br; i.jump = jp; i.call = ca; i.ret = re;
    i.tv = tv; i.imm = imm; i.tgt = tgt;
    return i;
  endfunction

  function automatic vec_t mk_vec(in_t i, logic [W-1:0] pc, logic e, logic f, logic u);
    vec_t v;
    v.in = i; v.pc = pc; v.e = e; v.f = f; v.u = u;
    return v;
  endfunction

  task automatic drive(input in_t i);
    bus.stall = i.stall; bus.trap = i.trap; bus.branch = i.branch; bus.jump = i.jump;
    bus.call = i.call; bus.ret = i.ret; bus.trap_vec = i.tv; bus.immediate = i.imm;
    bus.target = i.tgt;
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = '0;
    m_stack.delete();
    m_uf = 1'b0;
  endtask

  task automatic model_step(input in_t i);
    logic [W-1:0] seq, nxt;
    logic         had_entry;
    m_uf = 1'b0;
    if (i.trap) begin
      m_pc = i.tv;
    end else if (!i.stall) begin
      seq       = m_pc + 32'd1;
      had_entry = (m_stack.size() > 0);
      if (i.ret && had_entry) nxt = m_stack.pop_back();
      else if (i.jump)        nxt = i.tgt;
      else if (i.branch)      nxt = m_pc + i.imm;
      else                    nxt = seq;
      if (i.ret && !had_entry) m_uf = 1'b1;
      if (i.call) begin
        m_stack.push_back(seq);
        if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
      end
      m_pc = nxt;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " pc"},        bus.pc_out_reg,            m_pc);
    check({tag, " empty"},     W'(bus.ras_empty),         W'(m_stack.size() == 0));
    check({tag, " full"},      W'(bus.ras_full),          W'(m_stack.size() == DEPTH));
    check({tag, " underflow"}, W'(bus.ras_underflow),     W'(m_uf));
  endtask

  vec_t tbl[$];
  in_t  idle, r;

  initial begin
    idle = mk_in(0, 0, 0, 0, 0, 0, '0, '0, '0);
    // Idle counting, wrapping branch and wrapping sequential step
    tbl.push_back(mk_vec(idle, 32'd1, 1, 0, 0));
    tbl.push_back(mk_vec(idle, 32'd2, 1, 0, 0));
    tbl.push_back(mk_vec(idle, 32'd3, 1, 0, 0));
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 1, 0, 0, '0, '0, 32'd10), 32'd10, 1, 0, 0));
    tbl.push_back(mk_vec(mk_in(0, 0, 1, 0, 0, 0, '0, 32'hFFFF_FFFB, '0), 32'd5, 1, 0, 0));
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 1, 0, 0, '0, '0, 32'hFFFF_FFFF), 32'hFFFF_FFFF, 1, 0, 0));
    tbl.push_back(mk_vec(idle, 32'd0, 1, 0, 0));
    // Call with jump, return later
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 1, 0, 0, '0, '0, 32'd20), 32'd20, 1, 0, 0));
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 1, 1, 0, '0, '0, 32'd100), 32'd100, 0, 0, 0));
    tbl.push_back(mk_vec(idle, 32'd101, 0, 0, 0));
    tbl.push_back(mk_vec(idle, 32'd102, 0, 0, 0));
    tbl.push_back(mk_vec(idle, 32'd103, 0, 0, 0));
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 0, 0, 1, '0, '0, '0), 32'd21, 1, 0, 0));
    // Five calls overflow a 4-deep stack; pushes 22..26, 22 is lost
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 0, 1, 0, '0, '0, '0), 32'd22, 0, 0, 0));
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 0, 1, 0, '0, '0, '0), 32'd23, 0, 0, 0));
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 0, 1, 0, '0, '0, '0), 32'd24, 0, 0, 0));
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 0, 1, 0, '0, '0, '0), 32'd25, 0, 1, 0));
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 0, 1, 0, '0, '0, '0), 32'd26, 0, 1, 0));
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 0, 0, 1, '0, '0, '0), 32'd26, 0, 0, 0));
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 0, 0, 1, '0, '0, '0), 32'd25, 0, 0, 0));
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 0, 0, 1, '0, '0, '0), 32'd24, 0, 0, 0));
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 0, 0, 1, '0, '0, '0), 32'd23, 1, 0, 0));
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 0, 0, 1, '0, '0, '0), 32'd24, 1, 0, 1));
    tbl.push_back(mk_vec(idle, 32'd25, 1, 0, 0));
    // Stall blocks branch and call; trap overrides stall and leaves the stack alone
    tbl.push_back(mk_vec(mk_in(1, 0, 1, 0, 1, 0, '0, 32'd5, '0), 32'd25, 1, 0, 0));
    tbl.push_back(mk_vec(mk_in(1, 1, 0, 0, 1, 0, 32'h80, '0, '0), 32'h80, 1, 0, 0));
    tbl.push_back(mk_vec(idle, 32'h81, 1, 0, 0));
    // Call+ret together swaps the top; ret beats jump; jump beats branch
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 0, 1, 0, '0, '0, '0), 32'h82, 0, 0, 0));
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 0, 1, 1, '0, '0, '0), 32'h82, 0, 0, 0));
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 0, 0, 1, '0, '0, '0), 32'h83, 1, 0, 0));
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 0, 1, 0, '0, '0, '0), 32'h84, 0, 0, 0));
    tbl.push_back(mk_vec(mk_in(0, 0, 0, 1, 0, 1, '0, '0, 32'h200), 32'h84, 1, 0, 0));
    tbl.push_back(mk_vec(mk_in(0, 0, 1, 1, 0, 0, '0, 32'd4, 32'h300), 32'h300, 1, 0, 0));
    tbl.push_back(mk_vec(mk_in(0, 1, 0, 0, 0, 1, 32'h40, '0, '0), 32'h40, 1, 0, 0));

    drive(idle);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset pc", bus.pc_out_reg, 32'd0);
    check("reset empty", W'(bus.ras_empty), W'(1));
    check("reset full", W'(bus.ras_full), W'(0));
    check("reset underflow", W'(bus.ras_underflow), W'(0));
    rst = 1'b1;

    foreach (tbl[k]) begin
      drive(tbl[k].in);
      @(posedge clk);
      model_step(tbl[k].in);
      #1;
      check($sformatf("row%0d pc", k), bus.pc_out_reg, tbl[k].pc);
      check($sformatf("row%0d empty", k), W'(bus.ras_empty), W'(tbl[k].e));
      check($sformatf("row%0d full", k), W'(bus.ras_full), W'(tbl[k].f));
      check($sformatf("row%0d underflow", k), W'(bus.ras_underflow), W'(tbl[k].u));
    end

    for (int n = 0; n < 400; n++) begin
      r = mk_in($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                $urandom, ($urandom_range(0, 1) == 1) ? $urandom : W'($urandom_range(0, 64)),
                $urandom);
      drive(r);
      @(posedge clk);
      model_step(r);
      #1;
      check_model($sformatf("rand%0d", n));
    end

    // Build up stack content, then hit reset between edges while a call is pending
    drive(mk_in(0, 0, 0, 1, 1, 0, '0, '0, 32'h1000));
    @(posedge clk);
    model_step(mk_in(0, 0, 0, 1, 1, 0, '0, '0, 32'h1000));
    #1;
    check_model("pre-reset");
    #2;
    rst = 1'b0;
    #1;
    check("async reset pc", bus.pc_out_reg, 32'd0);
    check("async reset empty", W'(bus.ras_empty), W'(1));
    check("async reset underflow", W'(bus.ras_underflow), W'(0));
    model_reset();
    @(posedge clk);
    #1;
    check("held reset pc", bus.pc_out_reg, 32'd0);
    drive(idle);
    rst = 1'b1;
    @(posedge clk);
    model_step(idle);
    #1;
    check("post-reset pc", bus.pc_out_reg, 32'd1);
    check_model("post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning PC and address width in bits.
REQ-002 The module SHALL have parameter STEP, default 1, meaning the sequential increment added each unstalled cycle.
REQ-003 The module SHALL have parameter RESET_VECTOR, default 0, meaning the PC value loaded on reset.
REQ-004 The module SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of 2, >=2).
REQ-005 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit, reset that is asynchronous and active-low.
REQ-007 The module SHALL have port stall, input, 1 bit, meaning hold PC and RAS this cycle.
REQ-008 The module SHALL have port trap, input, 1 bit, meaning redirect to trap_vec.
REQ-009 The module SHALL have port trap_vec, input, WIDTH bits, the absolute trap target.
REQ-010 The module SHALL have port branch, input, 1 bit, meaning a taken PC-relative branch.
REQ-011 The module SHALL have port immediate, input, WIDTH bits, the two's-complement branch offset.
REQ-012 The module SHALL have port jump, input, 1 bit, meaning an absolute jump.
REQ-013 The module SHALL have port target, input, WIDTH bits, the absolute jump target.
REQ-014 The module SHALL have port call, input, 1 bit, meaning push pc_out+STEP onto the RAS.
REQ-015 The module SHALL have port ret, input, 1 bit, meaning pop the RAS and redirect to the popped value.
REQ-016 The module SHALL have port pc_out_reg, output, WIDTH bits, the registered current PC.
REQ-017 The module SHALL have ports ras_empty and ras_full, outputs, 1 bit each, giving combinational RAS occupancy flags.
REQ-018 The module SHALL have port ras_underflow, output, 1 bit, a registered one-cycle pulse when ret finds the RAS empty.

Function
REQ-019 Next-PC priority SHALL be: trap, then stall (hold), then ret (non-empty), then jump, then branch, then sequential.
REQ-020 trap SHALL load trap_vec even when stall=1, and SHALL leave the RAS unchanged.
REQ-021 stall=1 without trap SHALL hold pc_out_reg and SHALL suppress all RAS push and pop operations.
REQ-022 branch SHALL load pc_out_reg+immediate; sequential SHALL load pc_out_reg+STEP; all sums SHALL wrap modulo 2^WIDTH.
REQ-023 ret with a non-empty RAS SHALL load the top entry and pop it, decrementing the count.
REQ-024 ret with an empty RAS SHALL fall through to the next-lower priority source, and SHALL pulse ras_underflow for exactly one cycle.
REQ-025 call SHALL push pc_out_reg+STEP regardless of which source is selected (trap and stall excepted).
REQ-026 call with ret in the same cycle on a non-empty RAS SHALL redirect to the old top and replace the top with the pushed value, leaving the count unchanged.
REQ-027 A push when the RAS is full SHALL overwrite the oldest entry through circular pointer wrap; the count SHALL saturate at RAS_DEPTH.
REQ-028 ras_empty SHALL equal (count==0), and ras_full SHALL equal (count==RAS_DEPTH).
REQ-029 Each of the PC and the RAS SHALL have 1-cycle latency: a request in cycle N SHALL be visible on pc_out_reg or the flags in cycle N+1.

Reset
REQ-030 While rst=0, the module SHALL asynchronously set pc_out_reg=RESET_VECTOR, RAS count=0, stack pointer=0, all entries=0, and ras_underflow=0.
REQ-031 Reset asserted mid-operation SHALL discard any pending redirect or push.
REQ-032 The first rising edge after rst rises SHALL perform a normal next-PC update.

Structure
REQ-033 Package pc_gen_pkg SHALL hold the next-PC select enum (SEL_TRAP, SEL_HOLD, SEL_RET, SEL_JUMP, SEL_BRANCH, SEL_SEQ).
REQ-034 The RAS SHALL be sub-module pc_gen_ras, parametrised by WIDTH and RAS_DEPTH, with push/pop/data/empty/full ports.

Verification
REQ-035 Scenario SHALL cover: reset release, 3 idle cycles -> pc_out_reg 0,1,2,3.
REQ-036 Scenario SHALL cover: pc=10, branch with immediate=0xFFFFFFFB -> pc=5; pc=0xFFFFFFFF sequential -> pc=0.
REQ-037 Scenario SHALL cover: pc=20, call+jump to target=100, then ret at pc=103 -> pc=21, ras_empty=1.
REQ-038 Scenario SHALL cover: 5 calls on RAS_DEPTH=4 -> ras_full=1; then 4 rets return the 4 newest addresses and a 5th ret pulses ras_underflow with pc sequential.
REQ-039 Scenario SHALL cover: stall=1 with branch and call -> pc and count unchanged; stall=1 with trap and trap_vec=0x80 -> pc=0x80 next cycle.
REQ-040 Scenario SHALL cover: rst asserted asynchronously between edges during a call -> pc_out_reg=RESET_VECTOR immediately and ras_empty=1.
